// File: rtl/peripheral_mpram_axi4_pkg.sv
// Shared definitions for the MPRAM AXI4 slave front-end.
//   - AXI burst type encodings
//   - AXI response encodings
//   - front-end FSM state encoding
package peripheral_mpram_axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_RREQ  = 3'd3,
    ST_RSEND = 3'd4
  } state_e;

  // WRAP bursts must span 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/peripheral_mpram_axi4_slave_if.sv
// AXI4 bus bundle between interconnect (master) and the MPRAM front-end (slave).
//   AW/W/B : write address, write data, write response
//   AR/R   : read address, read data
// Parameters: ID_WIDTH, ADDR_WIDTH, DATA_WIDTH.
interface peripheral_mpram_axi4_slave_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/peripheral_mpram_axi4_addr_gen.sv
// Next RAM word address for an AXI burst beat.
//   addr_i  : current word address
//   burst_i : FIXED / INCR / WRAP
//   len_i   : AXI beat count minus one
//   addr_o  : word address of the following beat
module peripheral_mpram_axi4_addr_gen
  import peripheral_mpram_axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0]            burst_i,
  input  logic [7:0]            len_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    incr      = addr_i + ADDR_WIDTH'(1);
    // Legal wrap lengths are 2^n-1, so len itself is the mask of the wrapping bits.
    wrap_mask = ADDR_WIDTH'(len_i);
    case (burst_i)
      BURST_FIXED: addr_o = addr_i;
      BURST_WRAP:  addr_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
      default:     addr_o = incr;
    endcase
  end

endmodule

// File: rtl/peripheral_mpram_axi4_slave.sv
// AXI4 slave front-end for the MPRAM core: turns one AXI burst at a time into
// single-word RAM accesses, alternating fairly between reads and writes.
//   clk_i, rst_i : clock, synchronous active-high reset
//   axi          : AXI4 slave bundle (AW, W, B, AR, R)
//   mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_data_o : RAM request
//   mem_data_i   : RAM read data, one cycle after the address
//
// state  | meaning
// IDLE   | arbitrate AW/AR, wait for the granted address handshake
// WRITE  | accept W beats, one RAM write per beat
// WRESP  | present B until bready
// RREQ   | issue RAM read for the current beat
// RSEND  | present R beat until rready
module peripheral_mpram_axi4_slave
  import peripheral_mpram_axi4_pkg::*;
#(
  parameter  int AXI_ID_WIDTH   = 4,
  parameter  int AXI_ADDR_WIDTH = 12,
  parameter  int AXI_DATA_WIDTH = 32,
  localparam int BYTE_OFF       = $clog2(AXI_DATA_WIDTH/8),
  localparam int RAM_ADDR_WIDTH = AXI_ADDR_WIDTH - BYTE_OFF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  peripheral_mpram_axi4_slave_if.slave axi,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
  output logic [RAM_ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]   mem_data_o,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_data_i
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_WRITE = ST_WRITE;
  localparam logic [2:0] S_WRESP = ST_WRESP;
  localparam logic [2:0] S_RREQ  = ST_RREQ;
  localparam logic [2:0] S_RSEND = ST_RSEND;

  logic [2:0]                state_q;
  logic                      last_wr_q;
  logic                      awready_q;
  logic                      arready_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [7:0]                len_q;
  logic [1:0]                burst_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_next;
  logic [7:0]                beat_q;
  logic                      err_q;
  logic                      wlast_err_q;
  logic                      last_beat;
  logic                      w_fire;
  logic                      unused_addr;

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    return (size != 3'(BYTE_OFF)) || (burst == 2'b11) ||
           ((burst == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

  peripheral_mpram_axi4_addr_gen #(
    .ADDR_WIDTH(RAM_ADDR_WIDTH)
  ) u_addr_gen (
    .addr_i (addr_q),
    .burst_i(burst_q),
    .len_i  (len_q),
    .addr_o (addr_next)
  );

  assign last_beat = (beat_q == len_q);
  assign w_fire    = (state_q == S_WRITE) && axi.wvalid;

  // Sub-word byte offset bits carry no information for full-width accesses.
  assign unused_addr = ^{axi.awaddr, axi.araddr};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      last_wr_q   <= 1'b0;
      awready_q   <= 1'b0;
      arready_q   <= 1'b0;
      id_q        <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (awready_q && axi.awvalid) begin
            awready_q   <= 1'b0;
            last_wr_q   <= 1'b1;
            id_q        <= axi.awid;
            len_q       <= axi.awlen;
            burst_q     <= axi.awburst;
            addr_q      <= axi.awaddr[AXI_ADDR_WIDTH-1:BYTE_OFF];
            beat_q      <= '0;
            err_q       <= burst_err(axi.awsize, axi.awburst, axi.awlen);
            wlast_err_q <= 1'b0;
            state_q     <= S_WRITE;
          end else if (arready_q && axi.arvalid) begin
            arready_q   <= 1'b0;
            last_wr_q   <= 1'b0;
            id_q        <= axi.arid;
            len_q       <= axi.arlen;
            burst_q     <= axi.arburst;
            addr_q      <= axi.araddr[AXI_ADDR_WIDTH-1:BYTE_OFF];
            beat_q      <= '0;
            err_q       <= burst_err(axi.arsize, axi.arburst, axi.arlen);
            wlast_err_q <= 1'b0;
            state_q     <= S_RREQ;
          end else if (!awready_q && !arready_q) begin
            // Grant is registered so ready never depends combinationally on valid;
            // AXI forbids dropping valid, so the granted request is still there next cycle.
            if (axi.awvalid && (!axi.arvalid || !last_wr_q)) begin
              awready_q <= 1'b1;
            end else if (axi.arvalid) begin
              arready_q <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (axi.wvalid) begin
            // Misplaced wlast only affects the response; the beat count ends the burst.
            if (axi.wlast != last_beat) begin
              wlast_err_q <= 1'b1;
            end
            if (last_beat) begin
              state_q <= S_WRESP;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= addr_next;
            end
          end
        end
        S_WRESP: begin
          if (axi.bready) begin
            state_q <= S_IDLE;
          end
        end
        S_RREQ: begin
          state_q <= S_RSEND;
        end
        S_RSEND: begin
          if (axi.rready) begin
            if (last_beat) begin
              state_q <= S_IDLE;
            end else begin
              beat_q  <= beat_q + 8'd1;
              addr_q  <= addr_next;
              state_q <= S_RREQ;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign axi.awready = awready_q;
  assign axi.arready = arready_q;
  assign axi.wready  = (state_q == S_WRITE);

  assign axi.bvalid  = (state_q == S_WRESP);
  assign axi.bid     = axi.bvalid ? id_q : '0;
  assign axi.bresp   = (axi.bvalid && (err_q || wlast_err_q)) ? RESP_SLVERR : RESP_OKAY;

  assign axi.rvalid  = (state_q == S_RSEND);
  assign axi.rid     = axi.rvalid ? id_q : '0;
  assign axi.rdata   = (axi.rvalid && !err_q) ? mem_data_i : '0;
  assign axi.rresp   = (axi.rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign axi.rlast   = axi.rvalid && last_beat;

  assign mem_req_o   = (w_fire || (state_q == S_RREQ)) && !err_q;
  assign mem_we_o    = w_fire && !err_q;
  assign mem_be_o    = mem_we_o ? axi.wstrb : '0;
  assign mem_data_o  = mem_we_o ? axi.wdata : '0;
  // Address stays on the bus through RSEND so the RAM keeps rdata stable.
  assign mem_addr_o  = ((state_q == S_WRITE) || (state_q == S_RREQ) || (state_q == S_RSEND))
                       ? addr_q : '0;

endmodule

// File: tb/tb_peripheral_mpram_axi4_slave.sv
module tb_peripheral_mpram_axi4_slave;
  import peripheral_mpram_axi4_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:1023] = '{default: '0};

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int req_cnt = 0;
  int hs, hs_r, hs_w;
  logic [1:0] bresp_a;
  int req_before;
  int ordv;

  int          wl_addr[$];
  logic [31:0] wl_data[$];
  int          wl_cyc[$];
  int          ord[$];
  logic [31:0] rd_data[$];
  logic [1:0]  rd_resp[$];
  logic        rd_last[$];
  int          rd_cyc[$];

  always #5 clk_i = ~clk_i;

  peripheral_mpram_axi4_slave_if #(.ID_WIDTH(4), .ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  peripheral_mpram_axi4_slave #(
    .AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .axi       (bus),
    .mem_req_o (mem_req),
    .mem_we_o  (mem_we),
    .mem_be_o  (mem_be),
    .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata),
    .mem_data_i(mem_rdata)
  );

  // RAM model: byte-enabled write, registered read of the presented address.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_req && mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk_i) begin
    if (mem_req) req_cnt++;
    if (mem_req && mem_we) begin
      wl_addr.push_back(int'(mem_addr));
      wl_data.push_back(mem_wdata);
      wl_cyc.push_back(cyc);
    end
    if (bus.awvalid && bus.awready) ord.push_back(1);
    if (bus.arvalid && bus.arready) ord.push_back(0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_hs"}, {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, mem_req, mem_we}, 0);
    chk({tag, "_mem"}, {mem_be, mem_addr, mem_wdata}, 0);
    chk({tag, "_resp"}, {bus.bid, bus.bresp, bus.rid, bus.rresp, bus.rlast, bus.rdata}, 0);
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, output int hs_o);
    int n = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    while (!bus.awready && n < 20) begin @(posedge clk_i); #1; n++; end
    chk("aw_ready", bus.awready, 1'b1);
    hs_o = cyc;
    @(posedge clk_i); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, output int hs_o);
    int n = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    while (!bus.arready && n < 20) begin @(posedge clk_i); #1; n++; end
    chk("ar_ready", bus.arready, 1'b1);
    hs_o = cyc;
    @(posedge clk_i); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                           input logic [31:0] base, output logic [1:0] bresp, output int hs_o);
    int n;
    do_aw(id, addr, len, size, burst, hs_o);
    for (int b = 0; b <= int'(len); b++) begin
      bus.wvalid = 1'b1; bus.wdata = base + b; bus.wstrb = strb; bus.wlast = (b == int'(len));
      n = 0;
      while (!bus.wready && n < 20) begin @(posedge clk_i); #1; n++; end
      chk("w_ready", bus.wready, 1'b1);
      @(posedge clk_i); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(posedge clk_i); #1; n++; end
    chk("b_valid", bus.bvalid, 1'b1);
    chk("b_id", bus.bid, id);
    bresp = bus.bresp;
    @(posedge clk_i); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int stall_beat,
                          output int hs_o);
    int n;
    logic [31:0] v;
    rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_cyc.delete();
    do_ar(id, addr, len, size, burst, hs_o);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!bus.rvalid && n < 20) begin @(posedge clk_i); #1; n++; end
      chk("r_valid", bus.rvalid, 1'b1);
      if (!bus.rvalid) break;
      chk("r_id", bus.rid, id);
      rd_cyc.push_back(cyc);
      if (b == stall_beat) begin
        v = bus.rdata;
        repeat (5) begin
          @(posedge clk_i); #1;
          chk("stall_rvalid", bus.rvalid, 1'b1);
          chk("stall_rdata", bus.rdata, v);
        end
      end
      rd_data.push_back(bus.rdata);
      rd_resp.push_back(bus.rresp);
      rd_last.push_back(bus.rlast);
      bus.rready = 1'b1;
      @(posedge clk_i); #1;
      bus.rready = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    chk_quiet("reset");
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Simultaneous AW/AR three times: write wins first (last_wr resets to 0), then alternate.
    ord.delete();
    for (int k = 0; k < 3; k++) begin
      fork
        axi_write(4'h1, 12'h100, 8'd0, 3'd2, BURST_INCR, 4'hF, 32'h55 + k, bresp_a, hs_w);
        axi_read(4'h2, 12'h100, 8'd0, 3'd2, BURST_INCR, -1, hs_r);
      join
    end
    chk("arb_count", ord.size(), 6);
    ordv = 0;
    foreach (ord[i]) ordv = (ordv << 1) | ord[i];
    chk("arb_order", ordv, 6'b101010);

    // INCR write, words 4..7, one beat per cycle starting the cycle after AW handshake.
    wl_addr.delete(); wl_data.delete(); wl_cyc.delete();
    axi_write(4'h3, 12'h010, 8'd3, 3'd2, BURST_INCR, 4'hF, 32'd1, bresp_a, hs);
    chk("incr_bresp", bresp_a, RESP_OKAY);
    chk("incr_wcount", wl_addr.size(), 4);
    for (int i = 0; i < wl_addr.size() && i < 4; i++) begin
      chk($sformatf("incr_addr%0d", i), wl_addr[i], 4 + i);
      chk($sformatf("incr_data%0d", i), wl_data[i], 1 + i);
      chk($sformatf("incr_cyc%0d", i), wl_cyc[i] - hs, 1 + i);
    end

    // Read back: data 1..4, rlast on 4th beat, first rvalid 2 cycles after AR, 2 cycles/beat.
    axi_read(4'h4, 12'h010, 8'd3, 3'd2, BURST_INCR, -1, hs);
    chk("rb_count", rd_data.size(), 4);
    for (int i = 0; i < rd_data.size(); i++) begin
      chk($sformatf("rb_data%0d", i), rd_data[i], 1 + i);
      chk($sformatf("rb_last%0d", i), rd_last[i], i == 3);
      chk($sformatf("rb_resp%0d", i), rd_resp[i], RESP_OKAY);
    end
    if (rd_cyc.size() >= 2) begin
      chk("rb_first_lat", rd_cyc[0] - hs, 2);
      chk("rb_tput", rd_cyc[1] - rd_cyc[0], 2);
    end

    // WRAP len 3 from word 6: 6,7,4,5.
    wl_addr.delete(); wl_data.delete(); wl_cyc.delete();
    axi_write(4'h5, 12'h018, 8'd3, 3'd2, BURST_WRAP, 4'hF, 32'h10, bresp_a, hs);
    chk("wrap_bresp", bresp_a, RESP_OKAY);
    chk("wrap_wcount", wl_addr.size(), 4);
    if (wl_addr.size() == 4)
      chk("wrap_addrs", {8'(wl_addr[0]), 8'(wl_addr[1]), 8'(wl_addr[2]), 8'(wl_addr[3])}, 32'h06070405);

    // Illegal WRAP length: beats consumed, no RAM access, SLVERR.
    req_before = req_cnt;
    axi_write(4'h6, 12'h020, 8'd2, 3'd2, BURST_WRAP, 4'hF, 32'hDEAD, bresp_a, hs);
    chk("wrap2_bresp", bresp_a, RESP_SLVERR);
    chk("wrap2_noreq", req_cnt - req_before, 0);

    // Last served was a write, so a simultaneous pair now goes read first.
    ord.delete();
    fork
      axi_write(4'h7, 12'h104, 8'd0, 3'd2, BURST_INCR, 4'hF, 32'h77, bresp_a, hs_w);
      axi_read(4'h8, 12'h104, 8'd0, 3'd2, BURST_INCR, -1, hs_r);
    join
    chk("fair_count", ord.size(), 2);
    ordv = 0;
    foreach (ord[i]) ordv = (ordv << 1) | ord[i];
    chk("fair_order", ordv, 2'b01);

    // Narrow read: SLVERR, zero data, no RAM access, rlast on beat 1.
    req_before = req_cnt;
    axi_read(4'h9, 12'h010, 8'd1, 3'd1, BURST_INCR, -1, hs);
    chk("narrow_count", rd_data.size(), 2);
    for (int i = 0; i < rd_data.size(); i++) begin
      chk($sformatf("narrow_data%0d", i), rd_data[i], 0);
      chk($sformatf("narrow_resp%0d", i), rd_resp[i], RESP_SLVERR);
      chk($sformatf("narrow_last%0d", i), rd_last[i], i == 1);
    end
    chk("narrow_noreq", req_cnt - req_before, 0);

    // Stall beat 1 for 5 cycles; words 4..7 hold 0x12,0x13,0x10,0x11 after the WRAP write.
    axi_read(4'hA, 12'h010, 8'd3, 3'd2, BURST_INCR, 1, hs);
    chk("stall_count", rd_data.size(), 4);
    if (rd_data.size() == 4)
      chk("stall_data", {rd_data[0][7:0], rd_data[1][7:0], rd_data[2][7:0], rd_data[3][7:0]}, 32'h12131011);

    // Reset during beat 2 of a len-7 write.
    do_aw(4'hB, 12'h000, 8'd7, 3'd2, BURST_INCR, hs);
    for (int b = 0; b < 3; b++) begin
      bus.wvalid = 1'b1; bus.wdata = 32'hA0 + b; bus.wstrb = 4'hF; bus.wlast = 1'b0;
      if (b == 2) rst_i = 1'b1;
      @(posedge clk_i); #1;
    end
    bus.wvalid = 1'b0;
    chk_quiet("midrst");
    rst_i = 1'b0;
    bus.bready = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      chk("midrst_no_b", bus.bvalid, 1'b0);
    end
    bus.bready = 1'b0;
    axi_read(4'hC, 12'h000, 8'd0, 3'd2, BURST_INCR, -1, hs);
    chk("midrst_rcount", rd_data.size(), 1);
    if (rd_data.size() == 1) begin
      chk("midrst_rdata", rd_data[0], 32'hA0);
      chk("midrst_rresp", rd_resp[0], RESP_OKAY);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
